// File: rtl/mem_rw_sync_rx.sv
// mem_rw_sync_rx: clocked receiver for the dual-rail four-phase R/W token
// channel. Synchronizes both rails, issues one push per token into a small
// first-word-fall-through FIFO, and returns a registered acknowledge.
// Optional statistics counters are enabled with MEM_RW_SYNC_RX_STATS_EN.
module mem_rw_sync_rx #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rw_t,
  input  logic                         rw_f,
  output logic                         ack,
  output logic                         op_valid,
  output logic                         op_write,
  input  logic                         op_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         err_illegal
`ifdef MEM_RW_SYNC_RX_STATS_EN
  ,
  output logic [CNT_W-1:0]             rd_count,
  output logic [CNT_W-1:0]             wr_count
`endif
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  if (DEPTH < 2 || SYNC_STAGES < 2 || CNT_W < 1) begin : g_param_check
    $error("mem_rw_sync_rx: DEPTH>=2, SYNC_STAGES>=2, CNT_W>=1 required");
  end

  typedef enum logic {IDLE, WAIT_NULL} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] t_sync, f_sync;
  logic s_t, s_f, s_data, s_null, s_illegal;
  logic push, pop, full, err_set;

  logic             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Rail synchronizers: shift each rail through SYNC_STAGES flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_sync <= '0;
      f_sync <= '0;
    end else begin
      t_sync <= {t_sync[SYNC_STAGES-2:0], rw_t};
      f_sync <= {f_sync[SYNC_STAGES-2:0], rw_f};
    end
  end

  assign s_t       = t_sync[SYNC_STAGES-1];
  assign s_f       = f_sync[SYNC_STAGES-1];
  assign s_data    = s_t ^ s_f;
  assign s_null    = ~(s_t | s_f);
  assign s_illegal = s_t & s_f;

  assign op_valid = (fifo_level != '0);
  assign full     = (fifo_level == FULL_LVL);
  assign pop      = op_valid & op_ready;
  // Stale entries are masked so op_write reads 0 whenever the FIFO is empty.
  assign op_write = op_valid & mem[rd_ptr];

  // Handshake state register; ack is its own flop, free of rail decode glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      ack   <= (state_nxt == WAIT_NULL);
    end
  end

  // Next-state: one push per DATA token, full FIFO holds the producer off
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_illegal) begin
          err_set = 1'b1;
        end else if (s_data && !full) begin
          push      = 1'b1;
          state_nxt = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (s_illegal) begin
          err_set = 1'b1;
        end else if (s_null) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky illegal-code flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_illegal <= 1'b0;
    else if (err_set) err_illegal <= 1'b1;
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_t;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

`ifdef MEM_RW_SYNC_RX_STATS_EN
  // Saturating per-type push counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (push) begin
      if (s_t && wr_count != '1)  wr_count <= wr_count + 1'b1;
      if (!s_t && rd_count != '1) rd_count <= rd_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_rw_sync_rx.sv
// tb_mem_rw_sync_rx: self-checking bench for mem_rw_sync_rx (DEPTH=4,
// SYNC_STAGES=2). A queue of accepted tokens is the reference model; every
// pop observed on the output side is compared against its head.
module tb_mem_rw_sync_rx;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int LAT   = 3;   // SYNC_STAGES + 1
  localparam int BOUND = 200;

  logic clk = 1'b0;
  logic rst, rw_t, rw_f, ack, op_valid, op_write, op_ready, err_illegal;
  logic [LVL_W-1:0] fifo_level;
`ifdef MEM_RW_SYNC_RX_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  mem_rw_sync_rx #(.DEPTH(DEPTH), .SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rw_t(rw_t), .rw_f(rw_f), .ack(ack),
    .op_valid(op_valid), .op_write(op_write), .op_ready(op_ready),
    .fifo_level(fifo_level), .err_illegal(err_illegal)
`ifdef MEM_RW_SYNC_RX_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int max_lvl = DEPTH;
  logic exp_q[$];

  function automatic void chk(string name, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output-side scoreboard: every accepted pop must match the model's head
  always @(posedge clk) begin
    if (!rst) begin
      if (op_valid && op_ready) begin
        if (exp_q.size() == 0) chk("pop_without_token", 1, 0);
        else chk("pop_order", op_write, exp_q.pop_front());
      end
      chk("level_cap", int'(fifo_level <= max_lvl), 1);
    end
  end

  task automatic wait_ack(input logic lvl, output int n);
    n = 0;
    while (ack != lvl && n < BOUND) begin
      tick();
      n++;
    end
  endtask

  // One full four-phase token; recorded in the model when ack rises
  task automatic send(input logic w);
    int n;
    rw_t = w;
    rw_f = ~w;
    wait_ack(1'b1, n);
    chk("send_ack_rise", ack, 1);
    if (ack) exp_q.push_back(w);
    rw_t = 1'b0;
    rw_f = 1'b0;
    wait_ack(1'b0, n);
    chk("send_ack_fall", ack, 0);
  endtask

  task automatic pop_one();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  typedef struct {
    logic t;
    logic f;
    logic exp_write;
    int   exp_lat;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[3];
    logic drain_exp[4];
    int n;
    bit done;

    vecs[0] = '{t: 1'b1, f: 1'b0, exp_write: 1'b1, exp_lat: LAT};
    vecs[1] = '{t: 1'b0, f: 1'b1, exp_write: 1'b0, exp_lat: LAT};
    vecs[2] = '{t: 1'b1, f: 1'b0, exp_write: 1'b1, exp_lat: LAT};
    drain_exp[0] = 1'b1; drain_exp[1] = 1'b1; drain_exp[2] = 1'b0; drain_exp[3] = 1'b1;

    rst = 1'b1; rw_t = 1'b0; rw_f = 1'b0; op_ready = 1'b0;
    repeat (3) tick();
    chk("rst_ack", ack, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op_write", op_write, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_err", err_illegal, 0);
    rst = 1'b0;
    tick();

    // Single-token vectors: latency, head visibility, pop
    for (int i = 0; i < 3; i++) begin
      rw_t = vecs[i].t;
      rw_f = vecs[i].f;
      wait_ack(1'b1, n);
      chk("vec_rise_lat", n, vecs[i].exp_lat);
      chk("vec_op_valid", op_valid, 1);
      chk("vec_op_write", op_write, vecs[i].exp_write);
      chk("vec_level1", fifo_level, 1);
      if (ack) exp_q.push_back(vecs[i].exp_write);
      rw_t = 1'b0;
      rw_f = 1'b0;
      wait_ack(1'b0, n);
      chk("vec_fall_lat", n, vecs[i].exp_lat);
      pop_one();
      chk("vec_level0", fifo_level, 0);
    end

    // Token held long after ack: exactly one push
    rw_t = 1'b0; rw_f = 1'b1;
    wait_ack(1'b1, n);
    if (ack) exp_q.push_back(1'b0);
    repeat (20) tick();
    chk("hold_level", fifo_level, 1);
    chk("hold_ack", ack, 1);
    rw_f = 1'b0;
    wait_ack(1'b0, n);
    chk("hold_fall", ack, 0);
    chk("hold_level_after_null", fifo_level, 1);
    pop_one();
    chk("hold_drained", fifo_level, 0);

    // Illegal 11 code in IDLE
    rw_t = 1'b1; rw_f = 1'b1;
    repeat (5) tick();
    chk("ill_err", err_illegal, 1);
    chk("ill_ack", ack, 0);
    chk("ill_level", fifo_level, 0);
    rw_t = 1'b0; rw_f = 1'b0;
    repeat (6) tick();
    chk("ill_sticky", err_illegal, 1);
    chk("ill_no_push", fifo_level, 0);
    rst = 1'b1;
    #2;
    chk("ill_cleared_by_rst", err_illegal, 0);
    tick();
    rst = 1'b0;
    tick();

    // Full FIFO back-pressure and deferred push after a pop
    send(1'b0); send(1'b1); send(1'b1); send(1'b0);
    chk("bp_level_full", fifo_level, 4);
    rw_t = 1'b1; rw_f = 1'b0;
    repeat (8) tick();
    chk("bp_ack_held_low", ack, 0);
    chk("bp_level_still_full", fifo_level, 4);
    chk("bp_head_is_read", op_write, 0);
    pop_one();
    chk("bp_no_push_on_pop_edge", ack, 0);
    chk("bp_level_after_pop", fifo_level, 3);
    tick();
    chk("bp_ack_next_cycle", ack, 1);
    chk("bp_level_refill", fifo_level, 4);
    if (ack) exp_q.push_back(1'b1);
    rw_t = 1'b0;
    wait_ack(1'b0, n);
    chk("bp_ack_fall", ack, 0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_data", op_write, drain_exp[i]);
      pop_one();
    end
    chk("bp_drained", fifo_level, 0);

    // Streaming with consumer always ready: wraps pointers, level stays <=1
    max_lvl = 1;
    op_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(logic'(i % 2));
    tick();
    op_ready = 1'b0;
    max_lvl = DEPTH;
    chk("wrap_model_empty", exp_q.size(), 0);
    chk("wrap_level", fifo_level, 0);

    // Randomized tokens and consumer stalls
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(logic'($urandom_range(0, 1)));
          chk("rand_level", fifo_level, exp_q.size());
          repeat ($urandom_range(0, 3)) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          op_ready = logic'($urandom_range(0, 1));
          tick();
        end
      end
    join
    op_ready = 1'b1;
    n = 0;
    while (fifo_level != '0 && n < BOUND) begin
      tick();
      n++;
    end
    op_ready = 1'b0;
    chk("rand_drained", fifo_level, 0);
    chk("rand_model_empty", exp_q.size(), 0);

    // Asynchronous reset mid-handshake with a token still held
    send(1'b1);
    rw_t = 1'b1; rw_f = 1'b0;
    wait_ack(1'b1, n);
    chk("mid_ack_high", ack, 1);
    chk("mid_level2", fifo_level, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_ack", ack, 0);
    chk("mid_async_valid", op_valid, 0);
    chk("mid_async_write", op_write, 0);
    chk("mid_async_level", fifo_level, 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    wait_ack(1'b1, n);
    chk("mid_recapture_ack", ack, 1);
    chk("mid_recapture_level", fifo_level, 1);
    chk("mid_recapture_write", op_write, 1);
    if (ack) exp_q.push_back(1'b1);
`ifdef MEM_RW_SYNC_RX_STATS_EN
    chk("mid_wr_count", wr_count, 1);
    chk("mid_rd_count", rd_count, 0);
`endif
    rw_t = 1'b0;
    wait_ack(1'b0, n);
    chk("mid_ack_fall", ack, 0);
    pop_one();
    chk("mid_drained", fifo_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_rw_sync_rx.md
Name: mem_rw_sync_rx

Overview:
- Clocked receiving end of the dual-rail four-phase R/W token channel.
- Accepts a dual-rail read/write flag from the asynchronous memory-interface stage and drives that stage's acknowledge input.
- Converts each token into a synchronous valid/ready command.
- Buffers tokens in a small FIFO so the memory controller can stall without deadlocking the async pipeline.

Parameters:
- DEPTH, 4: FIFO entries; minimum 2.
- SYNC_STAGES, 2: flip-flop stages on each input rail; minimum 2.
- CNT_W, 16: width of the optional statistics counters.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rw_t  in  1  dual-rail true rail; DATA 1 means write.
- rw_f  in  1  dual-rail false rail; DATA 0 means read.
- ack  out  1  acknowledge to the producer's ack_in. High means "DATA consumed, return to NULL".
- op_valid  out  1  FIFO head holds a command.
- op_write  out  1  head command: 1 = write, 0 = read. Valid only while op_valid is high.
- op_ready  in  1  consumer pops the head when op_valid && op_ready.
- fifo_level  out  $clog2(DEPTH+1)  current number of entries.
- err_illegal  out  1  sticky; set when the synchronized rails read 11.

Behaviour:
- Reset values (asserted asynchronously):
  - ack=0, op_valid=0, op_write=0, fifo_level=0, err_illegal=0.
  - FIFO pointers=0, synchronizers=00, state=IDLE.
- Input capture: rw_t and rw_f each pass through SYNC_STAGES flops. The decoded code s={rw_t_sync, rw_f_sync} is:
  - 00 = NULL
  - 10 = DATA write
  - 01 = DATA read
  - 11 = illegal
- IDLE (ack=0):
  - s DATA and level<DEPTH: push the op (write = s[1]), set ack=1 on the same edge, go to WAIT_NULL.
  - s DATA and FIFO full: hold in IDLE with ack=0, no push. Back-pressure reaches the producer.
  - s=11: set err_illegal, no push, stay in IDLE.
  - s=00: stay in IDLE.
- WAIT_NULL (ack=1):
  - s=00: set ack=0 on that edge, go to IDLE.
  - s DATA (same token still held): stay, no push. Exactly one push per token.
  - s=11: set err_illegal, stay.
- Latency:
  - DATA arriving at the pins to ack rising: SYNC_STAGES+1 clocks.
  - Same edge as ack rising: op_valid rises if the FIFO was empty.
  - NULL at the pins to ack falling: SYNC_STAGES+1 clocks.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - First-word fall-through: op_write always shows the head entry.
- Simultaneous push and pop:
  - The full check uses the level before the pop, so a full FIFO with a pop in the same cycle does not push. The token is pushed on the next cycle.
  - Push and pop in the same cycle on a non-full FIFO leaves level unchanged and stores data correctly.
  - Pop when empty is ignored.
- fifo_level: push adds 1, pop subtracts 1, both together leaves it unchanged. It never exceeds DEPTH and never underflows.
- err_illegal clears only on rst.
- Reset mid-handshake:
  - ack drops immediately and FIFO contents are discarded.
  - A DATA token still held by the producer after reset is captured again as a new token once synchronized. The system is responsible for resetting both ends together.
- ack is a registered output with no combinational path from the rails, so it is glitch-free toward the async stage.

Optional Feature:
- Macro: MEM_RW_SYNC_RX_STATS_EN.
- Defined:
  - Adds output ports rd_count and wr_count, each CNT_W bits, reset to 0.
  - Each counter increments on every push of its op type.
  - Counters saturate at all-ones; they do not wrap.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Single write: from reset, rw=10 held until ack. Required response:
  - ack rises 3 clocks later (SYNC_STAGES=2).
  - op_valid=1 and op_write=1 on the same edge.
  - Drive rw=00: ack falls 3 clocks later. Pop: fifo_level goes 1 -> 0.
- Full back-pressure: op_ready=0, send 4 tokens in order R,W,W,R, then a 5th token W. Required response:
  - After the 4th token, fifo_level=4.
  - 5th token: ack stays 0.
  - Pulse op_ready for 1 cycle: head R pops, 5th token is pushed on the following cycle, ack rises.
  - Draining gives W,W,R,W.
- Hold DATA: hold rw=01 for 20 clocks after ack rises. Required response: exactly one push, fifo_level=1.
- Illegal code: drive rw=11 for 5 clocks in IDLE. Required response: err_illegal=1, no push, ack=0. err_illegal stays 1 until rst pulses.
- Wrap and concurrency: with op_ready=1, send 10 alternating tokens. Required response:
  - Output order matches input order.
  - Pointers wrap past DEPTH with no loss.
  - fifo_level never exceeds 1.
- Reset mid-operation: assert rst while ack=1 and fifo_level=2. Required response:
  - Outputs return to reset values asynchronously.
  - After rst is released with rw=10 still held, one new write is pushed.
  - With MEM_RW_SYNC_RX_STATS_EN defined: wr_count=1, rd_count=0.
